drive_arbiter: RTL and testbench
================================

# drive_arbiter

Arbitrates ownership of the drive train between three motion controllers: inductance escape, ball search and return/deliver. Each presents a packed motor command. The block grants one owner at a time by fixed priority and forwards that owner's command, registered, to the Dual PWM / motor driver. Whenever either motor reverses direction, or a pause ends, it inserts an H-bridge coast (dead-time) interval. It also holds a minimum ownership time so the search and deliver controllers cannot chatter.

## Interface
- DEAD_CYCLES, 50_000, coast cycles inserted on any direction reversal and after pause release (≥1; 0.5 ms at 100 MHz)
- MIN_HOLD, 1_000_000, cycles a grant must be held before requester 1 may preempt requester 2 (≥1)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- Pause  in  1  global hold; forces coast while high
- Req  in  3  request per controller; bit 0 = inductance escape (highest), bit 1 = ball search, bit 2 = return/deliver (lowest)
- Cmd0, Cmd1, Cmd2  in  8 each  packed command {FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA[1:0], Duty_SelB[1:0]}
- FWD_A, FWD_B, BWD_A, BWD_B  out  1 each  motor direction enables
- Duty_SelA, Duty_SelB  out  2 each  duty select to Dual PWM
- Grant  out  3  one-hot current or pending owner; 000 when none
- Fault  out  1  high each cycle an invalid command is being masked

## Operation
- States: IDLE, DRIVE, DEADTIME, PAUSED. All outputs and Grant are registered.
- **Priority** is fixed: 0 > 1 > 2.
- **Reset.** All outputs 0, Grant 000, state IDLE, counters 0. Reset wins over every other event. A reset during DRIVE or DEADTIME coasts the motors on the next edge.
- **IDLE.** Outputs 0.
  - Pause → PAUSED.
  - Otherwise any Req → DRIVE with the highest-priority requester. Grant is set and the hold counter cleared. No dead-time is needed because the motors are already coasting.
- **DRIVE.** Outputs track Cmd of the owner with one-cycle latency. The hold counter saturates at MIN_HOLD. Evaluated in this order:
  1. Pause → PAUSED.
  2. Owner Req low → the highest remaining requester becomes the new owner, or IDLE if none.
  3. A higher-priority Req preempts. Req[0] preempts immediately. Req[1] preempts owner 2 only when hold ≥ MIN_HOLD.
  4. Owner's own Cmd changes → tracked.
- **Reversal.** A new owner's Cmd, or a changed Cmd from the same owner, is a reversal if it drives motor A or B opposite to the current output (current FWD_x=1 and new BWD_x=1, or the reverse).
  - On reversal: enter DEADTIME and zero all outputs. Grant shows the pending owner.
  - Without reversal: apply the new Cmd on the next edge and clear the hold counter on an owner change.
- **DEADTIME.** Outputs 0. The counter runs to DEAD_CYCLES, then → DRIVE with the pending owner's current Cmd.
  - A higher-priority Req during DEADTIME replaces the pending owner without restarting the counter.
  - If the pending owner drops Req, the counter completes and the block re-arbitrates at expiry: the highest remaining requester gets DRIVE, or the block goes to IDLE.
  - Pause → PAUSED.
- **PAUSED.** Outputs 0, Grant 000, counter counts. It exits to IDLE only when Pause is low and at least DEAD_CYCLES have elapsed since entry. A short pause is therefore stretched to DEAD_CYCLES.
- **Invalid command** (FWD_x & BWD_x for the same motor): that motor's direction bits and its Duty_Sel are forced 0. The other motor passes through. Fault is high while the condition holds in DRIVE.
- **Counters.** Width is $clog2(max(DEAD_CYCLES, MIN_HOLD)+1). The hold counter saturates and never wraps. The dead-time counter clears on entry to DEADTIME or PAUSED.

## Timing
- Req/Cmd sampled at edge N → outputs and Grant valid after edge N+1.
- Reversal at edge N → outputs 0 from N+1. The new command appears at edge N+1+DEAD_CYCLES.
- Pause high at edge N → outputs 0 from N+1.
- Simultaneous Pause and preemption: Pause wins.
- Simultaneous owner drop and higher Req: the higher requester wins.
- Grant is never multi-hot. Outputs are never nonzero while Grant = 000.

## Test plan
Run with DEAD_CYCLES=4 and MIN_HOLD=8.
1. **Basic grant.** Reset, then Req=100 with Cmd2=8'hCA → next cycle Grant=100, {FWD_A,FWD_B,BWD_A,BWD_B}=1100, Duty_SelA=10, Duty_SelB=10. Req=000 → IDLE with outputs 0 one cycle later.
2. **Minimum hold.** Owner 2 holding FWD; Req[1] asserted 3 cycles after grant with Cmd1=8'hC8 → no preemption until hold=8. Then Grant=010, Duty_SelA=10, Duty_SelB=00, with no dead-time.
3. **Reversal preemption.** Owner 1 driving FWD (8'hC8); Req[0] with Cmd0=8'h3F → Grant=001, outputs 0 for exactly 4 cycles, then BWD_A=BWD_B=1 and Duty_Sel=11/11.
4. **Pause.** Pause high for 1 cycle during DRIVE → outputs 0 from the next cycle. Release to IDLE after 4 cycles, then DRIVE re-granted one cycle later.
5. **Invalid command.** Cmd1=8'hAA (FWD_A=BWD_A=1) → motor A bits and Duty_SelA are 0, motor B passes through, Fault=1 every cycle the command is held.
6. **Reset mid-operation.** Assert rst in the second DEADTIME cycle → next edge IDLE with all outputs 0, Grant=000, Fault=0.

Source files
------------

// File: rtl/drive_arbiter_if.sv
// Motor-command bundle between the motion controllers, the drive arbiter and the Dual PWM.
// The arbiter attaches through the slave modport; the controller/bench side uses master.
interface drive_arbiter_if;
  logic       Pause;
  logic [2:0] Req;
  logic [7:0] Cmd0;
  logic [7:0] Cmd1;
  logic [7:0] Cmd2;
  logic       FWD_A;
  logic       FWD_B;
  logic       BWD_A;
  logic       BWD_B;
  logic [1:0] Duty_SelA;
  logic [1:0] Duty_SelB;
  logic [2:0] Grant;
  logic       Fault;

  modport master (
    output Pause, Req, Cmd0, Cmd1, Cmd2,
    input  FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, Grant, Fault
  );

  modport slave (
    input  Pause, Req, Cmd0, Cmd1, Cmd2,
    output FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, Grant, Fault
  );
endinterface

// File: rtl/drive_arbiter.sv
// Fixed-priority drive-train arbiter: forwards the owner's motor command, registered, with
// H-bridge coast on reversal or pause release and a minimum hold before requester 1 preempts 2.
module drive_arbiter #(
  parameter int unsigned DEAD_CYCLES = 50_000,
  parameter int unsigned MIN_HOLD    = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  drive_arbiter_if.slave bus
);

  localparam int unsigned MaxCnt = (DEAD_CYCLES > MIN_HOLD) ? DEAD_CYCLES : MIN_HOLD;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] DeadMax  = CntW'(DEAD_CYCLES);
  localparam logic [CntW-1:0] HoldMax  = CntW'(MIN_HOLD);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StDead   = 2'd2;
  localparam logic [1:0] StPaused = 2'd3;

  // Command bit layout: {FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA[1:0], Duty_SelB[1:0]}
  function automatic logic [7:0] mask_cmd(input logic [7:0] c);
    logic [7:0] m;
    m = c;
    if (c[7] && c[5]) begin
      m[7]   = 1'b0;
      m[5]   = 1'b0;
      m[3:2] = 2'b00;
    end
    if (c[6] && c[4]) begin
      m[6]   = 1'b0;
      m[4]   = 1'b0;
      m[1:0] = 2'b00;
    end
    return m;
  endfunction

  function automatic logic invalid_cmd(input logic [7:0] c);
    return (c[7] & c[5]) | (c[6] & c[4]);
  endfunction

  function automatic logic reverses(input logic [7:0] cur, input logic [7:0] nxt);
    return (cur[7] & nxt[5]) | (cur[5] & nxt[7]) | (cur[6] & nxt[4]) | (cur[4] & nxt[6]);
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [1:0]      owner_q, owner_d;  // index of current (DRIVE) or pending (DEADTIME) owner
  logic [2:0]      grant_q, grant_d;
  logic [7:0]      out_q, out_d;
  logic            fault_q, fault_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic [CntW-1:0] dead_q, dead_d;

  logic       any_req;
  logic [1:0] top;
  logic [1:0] tgt;
  logic       arb, go_pause, go_idle;
  logic [7:0] sel_cmd, masked;

  assign any_req = |bus.Req;
  assign top     = bus.Req[0] ? 2'd0 : (bus.Req[1] ? 2'd1 : 2'd2);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    out_d    = out_q;
    fault_d  = 1'b0;
    hold_d   = hold_q;
    dead_d   = dead_q;
    arb      = 1'b0;
    go_pause = 1'b0;
    go_idle  = 1'b0;
    tgt      = owner_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Pause) begin
          go_pause = 1'b1;
        end else if (any_req) begin
          arb = 1'b1;
          tgt = top;
        end
      end
      StDrive: begin
        if (bus.Pause) begin
          go_pause = 1'b1;
        end else if (!bus.Req[owner_q]) begin
          if (any_req) begin
            arb = 1'b1;
            tgt = top;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          arb = 1'b1;
          if (bus.Req[0] && owner_q != 2'd0) begin
            tgt = 2'd0;
          end else if (bus.Req[1] && owner_q == 2'd2 && hold_q >= HoldMax) begin
            tgt = 2'd1;
          end
        end
      end
      StDead: begin
        if (bus.Pause) begin
          go_pause = 1'b1;
        end else if (dead_q >= DeadLast) begin
          // Coast done: re-arbitrate, since the pending owner may have dropped meanwhile
          if (any_req) begin
            arb = 1'b1;
            tgt = top;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          dead_d = dead_q + 1'b1;
          if (any_req && top < owner_q) begin
            owner_d = top;
            grant_d = onehot(top);
          end
        end
      end
      default: begin
        if (!bus.Pause && dead_q >= DeadLast) begin
          go_idle = 1'b1;
        end else if (dead_q < DeadMax) begin
          dead_d = dead_q + 1'b1;
        end
      end
    endcase

    case (tgt)
      2'd0:    sel_cmd = bus.Cmd0;
      2'd1:    sel_cmd = bus.Cmd1;
      default: sel_cmd = bus.Cmd2;
    endcase
    masked = mask_cmd(sel_cmd);

    if (go_pause) begin
      state_d = StPaused;
      out_d   = 8'h00;
      grant_d = 3'b000;
      dead_d  = '0;
      hold_d  = '0;
    end else if (go_idle) begin
      state_d = StIdle;
      out_d   = 8'h00;
      grant_d = 3'b000;
      hold_d  = '0;
    end else if (arb) begin
      owner_d = tgt;
      grant_d = onehot(tgt);
      if (reverses(out_q, masked)) begin
        state_d = StDead;
        out_d   = 8'h00;
        dead_d  = '0;
      end else begin
        state_d = StDrive;
        out_d   = masked;
        fault_d = invalid_cmd(sel_cmd);
        if (state_q == StDrive && tgt == owner_q) begin
          hold_d = (hold_q < HoldMax) ? hold_q + 1'b1 : hold_q;
        end else begin
          hold_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      grant_q <= 3'b000;
      out_q   <= 8'h00;
      fault_q <= 1'b0;
      hold_q  <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      fault_q <= fault_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
    end
  end

  assign {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B, bus.Duty_SelA, bus.Duty_SelB} = out_q;
  assign bus.Grant = grant_q;
  assign bus.Fault = fault_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a behavioural ownership model.
module tb_drive_arbiter;
  localparam int DEAD = 4;
  localparam int HOLD = 8;

  localparam int MIdle   = 0;
  localparam int MDrive  = 1;
  localparam int MCoast  = 2;
  localparam int MPaused = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  drive_arbiter_if bus ();

  drive_arbiter #(
    .DEAD_CYCLES(DEAD),
    .MIN_HOLD   (HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // Behavioural model: who owns the motors and what they see
  int       m_mode;
  int       m_owner;
  bit [7:0] m_out;
  bit       m_fault;
  int       m_held;
  int       m_coast_left;
  int       m_pause_age;

  logic [11:0] act_v;
  logic [11:0] exp_v;
  logic [7:0]  pool [8];

  function automatic bit [7:0] motor_view(input bit [7:0] c);
    bit       fa = c[7];
    bit       fb = c[6];
    bit       ba = c[5];
    bit       bb = c[4];
    bit [1:0] da = c[3:2];
    bit [1:0] db = c[1:0];
    if (fa && ba) begin fa = 0; ba = 0; da = 0; end
    if (fb && bb) begin fb = 0; bb = 0; db = 0; end
    return {fa, fb, ba, bb, da, db};
  endfunction

  function automatic bit is_bad(input bit [7:0] c);
    return (c[7] && c[5]) || (c[6] && c[4]);
  endfunction

  function automatic bit flips(input bit [7:0] cur, input bit [7:0] nxt);
    return (cur[7] && nxt[5]) || (cur[5] && nxt[7]) || (cur[6] && nxt[4]) || (cur[4] && nxt[6]);
  endfunction

  task automatic model_quiet(input int mode);
    m_mode  = mode;
    m_owner = -1;
    m_out   = 8'h00;
    if (mode == MPaused) m_pause_age = 0;
  endtask

  task automatic model_take(input int who, input bit [7:0] raw);
    bit [7:0] v = motor_view(raw);
    if (flips(m_out, v)) begin
      m_mode       = MCoast;
      m_out        = 8'h00;
      m_coast_left = DEAD;
    end else begin
      if (m_mode == MDrive && who == m_owner) m_held = (m_held < HOLD) ? m_held + 1 : HOLD;
      else m_held = 0;
      m_mode  = MDrive;
      m_out   = v;
      m_fault = is_bad(raw);
    end
    m_owner = who;
  endtask

  task automatic model_step(input bit rs, input bit pz, input bit [2:0] rq,
                            input bit [7:0] c0, input bit [7:0] c1, input bit [7:0] c2);
    bit [7:0] cmds [3];
    int top;
    cmds[0] = c0; cmds[1] = c1; cmds[2] = c2;
    m_fault = 1'b0;
    if (rs) begin
      model_quiet(MIdle);
      m_held = 0;
      return;
    end
    top = rq[0] ? 0 : (rq[1] ? 1 : (rq[2] ? 2 : -1));
    case (m_mode)
      MIdle: begin
        if (pz) model_quiet(MPaused);
        else if (top >= 0) model_take(top, cmds[top]);
      end
      MDrive: begin
        if (pz) model_quiet(MPaused);
        else if (!rq[m_owner]) begin
          if (top >= 0) model_take(top, cmds[top]);
          else model_quiet(MIdle);
        end else if (top == 0 && m_owner != 0) model_take(0, cmds[0]);
        else if (rq[1] && m_owner == 2 && m_held >= HOLD) model_take(1, cmds[1]);
        else model_take(m_owner, cmds[m_owner]);
      end
      MCoast: begin
        if (pz) model_quiet(MPaused);
        else begin
          m_coast_left--;
          if (m_coast_left == 0) begin
            if (top >= 0) model_take(top, cmds[top]);
            else model_quiet(MIdle);
          end else if (top >= 0 && top < m_owner) m_owner = top;
        end
      end
      default: begin
        m_pause_age++;
        if (!pz && m_pause_age >= DEAD) model_quiet(MIdle);
      end
    endcase
  endtask

  function automatic logic [2:0] model_grant();
    if (m_mode == MDrive || m_mode == MCoast) return 3'(1 << m_owner);
    return 3'b000;
  endfunction

  function automatic logic [11:0] dut_view();
    return {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B, bus.Duty_SelA, bus.Duty_SelB,
            bus.Grant, bus.Fault};
  endfunction

  always @(posedge clk) begin
    model_step(rst, bus.Pause, bus.Req, bus.Cmd0, bus.Cmd1, bus.Cmd2);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      act_v = dut_view();
      exp_v = {m_out, model_grant(), m_fault};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: got %h want %h", $time, act_v, exp_v);
      end
      vectors++;
      if ($countones(bus.Grant) > 1 || (bus.Grant == 3'b000 && act_v[11:4] != 8'h00)) begin
        miscompares++;
        $display("FAIL grant_invariant t=%0t: got grant %b out %h want one-hot or idle-coast",
                 $time, bus.Grant, act_v[11:4]);
      end
    end
  end

  task automatic lit(input string name, input logic [11:0] want);
    logic [11:0] got = dut_view();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [7:0] pick_cmd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom());
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    pool = '{8'hCA, 8'hC8, 8'h3F, 8'hAA, 8'h55, 8'h8C, 8'h11, 8'h00};
    bus.Pause = 1'b0;
    bus.Req   = 3'b000;
    bus.Cmd0  = 8'h00;
    bus.Cmd1  = 8'h00;
    bus.Cmd2  = 8'h00;
    repeat (2) @(negedge clk);
    lit("reset_state", 12'h000);

    // Basic grant
    rst      = 1'b0;
    bus.Req  = 3'b100;
    bus.Cmd2 = 8'hCA;
    @(negedge clk);
    lit("basic_grant", {8'hCA, 3'b100, 1'b0});
    bus.Req = 3'b000;
    @(negedge clk);
    lit("basic_idle", 12'h000);

    // Minimum hold before requester 1 takes over from 2
    bus.Req  = 3'b100;
    bus.Cmd1 = 8'hC8;
    @(negedge clk);
    lit("hold_grant", {8'hCA, 3'b100, 1'b0});
    repeat (2) @(negedge clk);
    bus.Req = 3'b110;
    repeat (6) @(negedge clk);
    lit("hold_not_yet", {8'hCA, 3'b100, 1'b0});
    @(negedge clk);
    lit("hold_preempt", {8'hC8, 3'b010, 1'b0});

    // Reversal preemption by requester 0
    bus.Req  = 3'b011;
    bus.Cmd0 = 8'h3F;
    @(negedge clk);
    lit("rev_coast", {8'h00, 3'b001, 1'b0});
    repeat (3) @(negedge clk);
    lit("rev_coast_last", {8'h00, 3'b001, 1'b0});
    @(negedge clk);
    lit("rev_apply", {8'h3F, 3'b001, 1'b0});

    // One-cycle pause stretched to the coast time
    bus.Pause = 1'b1;
    @(negedge clk);
    lit("pause_coast", 12'h000);
    bus.Pause = 1'b0;
    repeat (4) @(negedge clk);
    lit("pause_idle", 12'h000);
    @(negedge clk);
    lit("pause_regrant", {8'h3F, 3'b001, 1'b0});

    // Invalid command on motor A
    bus.Req  = 3'b010;
    bus.Cmd1 = 8'hAA;
    @(negedge clk);
    lit("invalid_mask", {8'h02, 3'b010, 1'b1});
    repeat (2) @(negedge clk);
    lit("invalid_hold", {8'h02, 3'b010, 1'b1});

    // Reset in the second dead-time cycle
    bus.Cmd1 = 8'hC8;
    @(negedge clk);
    lit("cmd_track", {8'hC8, 3'b010, 1'b0});
    bus.Req = 3'b011;
    @(negedge clk);
    lit("second_rev_coast", {8'h00, 3'b001, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lit("reset_mid_coast", 12'h000);
    rst     = 1'b0;
    bus.Req = 3'b000;

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      bus.Pause = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) bus.Req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bus.Cmd0 = pick_cmd();
      if ($urandom_range(0, 7) == 0) bus.Cmd1 = pick_cmd();
      if ($urandom_range(0, 7) == 0) bus.Cmd2 = pick_cmd();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
